// File: rtl/dmem_arbiter_if.sv
// Bundle between the two data-port requesters, the arbiter and cpu_mem's data port.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int AW = 32
);
  logic [1:0]    req;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [31:0]   wd0;
  logic [31:0]   wd1;
  logic          we0;
  logic          we1;
  logic [1:0]    dt0;
  logic [1:0]    dt1;
  logic [1:0]    gnt;
  logic [1:0]    done;
  logic [1:0]    err;
  logic [31:0]   rd;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wd;
  logic          m_we;
  logic [1:0]    m_dt;
  logic [31:0]   m_rd;

  modport slave (
    input  req, addr0, addr1, wd0, wd1, we0, we1, dt0, dt1, m_rd,
    output gnt, done, err, rd, m_addr, m_wd, m_we, m_dt
  );

  modport master (
    output req, addr0, addr1, wd0, wd1, we0, we1, dt0, dt1, m_rd,
    input  gnt, done, err, rd, m_addr, m_wd, m_we, m_dt
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares cpu_mem's data port between the CPU LSU (port 0) and an external master (port 1).
// Define DMEM_ARB_CPU_PRIO_EN for fixed CPU priority; otherwise arbitration is round-robin.
module dmem_arbiter #(
  parameter int ACC_CYC = 1,
  parameter int AW      = 32
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);
  localparam logic [1:0] DT_HALF = 2'd1;
  localparam logic [1:0] DT_WORD = 2'd2;
  localparam int CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACC_CYC - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          win_q, win_d;
  logic          we_q, we_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic [31:0]   rd_q, rd_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [31:0]   m_wd_q, m_wd_d;
  logic          m_we_q, m_we_d;
  logic [1:0]    m_dt_q, m_dt_d;
`ifndef DMEM_ARB_CPU_PRIO_EN
  logic          rr_q, rr_d;
`endif

  logic          pick;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wd;
  logic          sel_we;
  logic [1:0]    sel_dt;
  logic          misalign;

  always_comb begin
`ifdef DMEM_ARB_CPU_PRIO_EN
    pick = ~bus.req[0];
`else
    pick = (bus.req == 2'b11) ? rr_q : bus.req[1];
`endif
    sel_addr = pick ? bus.addr1 : bus.addr0;
    sel_wd   = pick ? bus.wd1   : bus.wd0;
    sel_we   = pick ? bus.we1   : bus.we0;
    sel_dt   = pick ? bus.dt1   : bus.dt0;
    misalign = ((sel_dt == DT_HALF) && sel_addr[0]) ||
               ((sel_dt == DT_WORD) && (sel_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    we_d     = we_q;
    gnt_d    = gnt_q;
    done_d   = done_q;
    err_d    = err_q;
    rd_d     = rd_q;
    m_addr_d = m_addr_q;
    m_wd_d   = m_wd_q;
    m_we_d   = m_we_q;
    m_dt_d   = m_dt_q;
`ifndef DMEM_ARB_CPU_PRIO_EN
    rr_d     = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          win_d = pick;
          if (misalign) begin
            state_d = DONE;
            done_d  = {pick, ~pick};
            err_d   = {pick, ~pick};
          end else begin
            state_d  = ACCESS;
            cnt_d    = CNT_LOAD;
            we_d     = sel_we;
            gnt_d    = {pick, ~pick};
            m_addr_d = sel_addr;
            m_wd_d   = sel_wd;
            m_dt_d   = sel_dt;
            m_we_d   = (ACC_CYC == 1) ? sel_we : 1'b0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          rd_d    = bus.m_rd;
          gnt_d   = 2'b00;
          m_we_d  = 1'b0;
          done_d  = {win_q, ~win_q};
        end else begin
          cnt_d = cnt_q - 1'b1;
          // Strobe the write only on the final cycle so an aborted access never commits.
          if (cnt_q == CW'(1)) m_we_d = we_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 2'b00;
        err_d   = 2'b00;
`ifndef DMEM_ARB_CPU_PRIO_EN
        rr_d    = ~win_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      rd_q     <= 32'h0;
      m_addr_q <= '0;
      m_wd_q   <= 32'h0;
      m_we_q   <= 1'b0;
      m_dt_q   <= DT_WORD;
`ifndef DMEM_ARB_CPU_PRIO_EN
      rr_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      we_q     <= we_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      m_addr_q <= m_addr_d;
      m_wd_q   <= m_wd_d;
      m_we_q   <= m_we_d;
      m_dt_q   <= m_dt_d;
`ifndef DMEM_ARB_CPU_PRIO_EN
      rr_q     <= rr_d;
`endif
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.rd     = rd_q;
  assign bus.m_addr = m_addr_q;
  assign bus.m_wd   = m_wd_q;
  assign bus.m_we   = m_we_q;
  assign bus.m_dt   = m_dt_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: vector table plus contention and reset-abort sequences,
// checked through an expected-result queue against a small behavioural cpu_mem model.
module tb_dmem_arbiter;
  localparam logic [1:0] DT_BYTE = 2'd0;
  localparam logic [1:0] DT_HALF = 2'd1;
  localparam logic [1:0] DT_WORD = 2'd2;

  typedef struct {
    bit          port;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          we;
    logic [1:0]  dt;
    bit          exp_err;
    bit          chk_rd;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_exp;
  } vec_t;

  typedef struct {
    bit          port;
    bit          err;
    bit          chk_rd;
    logic [31:0] rd;
    int          lat;
  } sb_t;

  logic clk;
  logic rst_n;
  logic mem_init;
  logic [31:0] mem  [256];
  logic [31:0] mem3 [256];
  sb_t  sb_q[$];
  int   errors;
  int   checks;
  int   we_cnt;
  int   oth_cnt;

  dmem_arbiter_if #(.AW(32)) bus ();
  dmem_arbiter_if #(.AW(32)) bus3 ();

  dmem_arbiter #(.ACC_CYC(1), .AW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  dmem_arbiter #(.ACC_CYC(3), .AW(32)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] lo,
                                        input logic [31:0] wd, input logic [1:0] dt);
    logic [31:0] r;
    r = old;
    case (dt)
      DT_BYTE: r[{lo, 3'b000} +: 8]      = wd[7:0];
      DT_HALF: r[{lo[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Behavioural cpu_mem data ports: asynchronous read, write on the rising edge.
  assign bus.m_rd  = mem[bus.m_addr[9:2]];
  assign bus3.m_rd = mem3[bus3.m_addr[9:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[65] <= 32'hc001c0de;
    end else if (bus.m_we) begin
      mem[bus.m_addr[9:2]] <= merge(mem[bus.m_addr[9:2]], bus.m_addr[1:0], bus.m_wd, bus.m_dt);
    end
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem3[i] <= 32'ha5a5a5a5;
    end else if (bus3.m_we) begin
      mem3[bus3.m_addr[9:2]] <= merge(mem3[bus3.m_addr[9:2]], bus3.m_addr[1:0], bus3.m_wd, bus3.m_dt);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for a done pulse, counting write strobes and grants outside the allowed mask.
  task automatic waitDone(input logic [1:0] mask, output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 16) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.m_we) we_cnt++;
      if ((bus.gnt & ~mask) != 2'b00) oth_cnt++;
      if (|bus.done) got = 1'b1;
    end
  endtask

  task automatic scoreboardCheck(input int cyc, input bit got);
    sb_t e;
    if (sb_q.size() == 0) begin
      checkOutput("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    if (!got) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("done_port", 32'(bus.done), e.port ? 32'd2 : 32'd1);
    checkOutput("err", 32'(bus.err), e.err ? (e.port ? 32'd2 : 32'd1) : 32'd0);
    if (e.chk_rd) checkOutput("rd", bus.rd, e.rd);
    checkOutput("latency", 32'(cyc), 32'(e.lat));
  endtask

  task automatic applyStimulus(input vec_t v);
    sb_t e;
    int  cyc;
    bit  got;
    @(negedge clk);
    if (v.port) begin
      bus.addr1 = v.addr; bus.wd1 = v.wd; bus.we1 = v.we; bus.dt1 = v.dt;
    end else begin
      bus.addr0 = v.addr; bus.wd0 = v.wd; bus.we0 = v.we; bus.dt0 = v.dt;
    end
    bus.req  = v.port ? 2'b10 : 2'b01;
    e.port   = v.port;
    e.err    = v.exp_err;
    e.chk_rd = v.chk_rd;
    e.rd     = v.exp_rd;
    e.lat    = v.exp_lat;
    sb_q.push_back(e);
    we_cnt  = 0;
    oth_cnt = 0;
    waitDone(v.port ? 2'b10 : 2'b01, cyc, got);
    scoreboardCheck(cyc, got);
    bus.req = 2'b00;
    checkOutput("we_pulses", 32'(we_cnt), 32'(v.exp_we));
    checkOutput("other_gnt", 32'(oth_cnt), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("mem_word", mem[v.mem_addr[9:2]], v.mem_exp);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    bit   order[4];
    sb_t  e;
    int   cyc;
    bit   got;

    errors = 0;
    checks = 0;
    we_cnt = 0;
    oth_cnt = 0;
    //            port  addr          wd            we    dt       err   chk   rd            lat we  mem_addr      mem_exp
    vecs[0] = '{1'b0, 32'h100, 32'hdeadbeef, 1'b1, DT_HALF, 1'b0, 1'b0, 32'h0,        2, 1, 32'h100, 32'h0000beef};
    vecs[1] = '{1'b1, 32'h104, 32'h0,        1'b0, DT_WORD, 1'b0, 1'b1, 32'hc001c0de, 2, 0, 32'h104, 32'hc001c0de};
    vecs[2] = '{1'b0, 32'h102, 32'hffffffff, 1'b1, DT_WORD, 1'b1, 1'b0, 32'h0,        1, 0, 32'h100, 32'h0000beef};
    vecs[3] = '{1'b1, 32'h103, 32'h0,        1'b0, DT_HALF, 1'b1, 1'b1, 32'hc001c0de, 1, 0, 32'h100, 32'h0000beef};
    vecs[4] = '{1'b0, 32'h109, 32'h000000aa, 1'b1, DT_BYTE, 1'b0, 1'b0, 32'h0,        2, 1, 32'h108, 32'h0000aa00};
    vecs[5] = '{1'b1, 32'h108, 32'h0,        1'b0, DT_WORD, 1'b0, 1'b1, 32'h0000aa00, 2, 0, 32'h108, 32'h0000aa00};
    vecs[6] = '{1'b1, 32'h107, 32'h00000055, 1'b1, DT_BYTE, 1'b0, 1'b0, 32'h0,        2, 1, 32'h104, 32'h5501c0de};

    rst_n = 1'b0;
    mem_init = 1'b1;
    bus.req = 2'b00;
    bus.addr0 = 32'h0; bus.addr1 = 32'h0; bus.wd0 = 32'h0; bus.wd1 = 32'h0;
    bus.we0 = 1'b0; bus.we1 = 1'b0; bus.dt0 = DT_WORD; bus.dt1 = DT_WORD;
    bus3.req = 2'b00;
    bus3.addr0 = 32'h0; bus3.addr1 = 32'h0; bus3.wd0 = 32'h0; bus3.wd1 = 32'h0;
    bus3.we0 = 1'b0; bus3.we1 = 1'b0; bus3.dt0 = DT_WORD; bus3.dt1 = DT_WORD;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_gnt", 32'(bus.gnt), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_err", 32'(bus.err), 32'd0);
    checkOutput("rst_rd", bus.rd, 32'h0);
    checkOutput("rst_m_we", 32'(bus.m_we), 32'd0);
    checkOutput("rst_m_addr", bus.m_addr, 32'h0);
    checkOutput("rst_m_wd", bus.m_wd, 32'h0);
    checkOutput("rst_m_dt", 32'(bus.m_dt), 32'(DT_WORD));
    checkOutput("rst3_m_we", 32'(bus3.m_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_init = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Both ports held requesting for four transactions.
    $display("[TB] contention sequence");
`ifdef DMEM_ARB_CPU_PRIO_EN
    order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    @(negedge clk);
    bus.addr0 = 32'h100; bus.we0 = 1'b0; bus.dt0 = DT_WORD;
    bus.addr1 = 32'h104; bus.we1 = 1'b0; bus.dt1 = DT_WORD;
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      e.port   = order[k];
      e.err    = 1'b0;
      e.chk_rd = 1'b1;
      e.rd     = order[k] ? 32'h5501c0de : 32'h0000beef;
      e.lat    = (k == 0) ? 2 : 3;
      sb_q.push_back(e);
    end
    for (int k = 0; k < 4; k++) begin
      waitDone(2'b11, cyc, got);
      scoreboardCheck(cyc, got);
    end
    bus.req = 2'b00;
    @(posedge clk);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);

    // Reset lands mid-access on the three-cycle instance.
    $display("[TB] reset during access");
    @(negedge clk);
    bus3.addr0 = 32'h108; bus3.wd0 = 32'h12345678; bus3.we0 = 1'b1; bus3.dt0 = DT_WORD;
    bus3.req = 2'b01;
    @(posedge clk);
    #1;
    checkOutput("acc3_gnt", 32'(bus3.gnt), 32'd1);
    checkOutput("acc3_m_we_c1", 32'(bus3.m_we), 32'd0);
    checkOutput("acc3_m_addr", bus3.m_addr, 32'h108);
    @(posedge clk);
    #1;
    checkOutput("acc3_m_we_c2", 32'(bus3.m_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_gnt", 32'(bus3.gnt), 32'd0);
    checkOutput("abort_m_we", 32'(bus3.m_we), 32'd0);
    checkOutput("abort_done", 32'(bus3.done), 32'd0);
    bus3.req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort_mem", mem3[66], 32'ha5a5a5a5);
    checkOutput("abort_done_after", 32'(bus3.done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
